// File: rtl/rssb_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rssb_seq_if                                                  |
// | Description : Bundle of job handshake, result and CPU pin signals for the  |
// |               RSSB bit-serial sequencer.                                   |
// |   Job side  : in_valid/in_ready/in_a, abort                                |
// |   Result    : out_valid/out_ready/out_result/out_flag_mask                 |
// |   CPU side  : cpu_ph1/cpu_ph2/cpu_rst_n/cpu_ena/cpu_din (to CPU),          |
// |               cpu_result/cpu_flag (from CPU)                               |
// |   Modports  : slave  = sequencer view                                      |
// |               master = job source / result sink / CPU view                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rssb_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_flag_mask;
  logic             cpu_ph1;
  logic             cpu_ph2;
  logic             cpu_rst_n;
  logic             cpu_ena;
  logic             cpu_din;
  logic             cpu_result;
  logic             cpu_flag;

  modport slave (
    input  in_valid, in_a, abort, out_ready, cpu_result, cpu_flag,
    output in_ready, out_valid, out_result, out_flag_mask,
           cpu_ph1, cpu_ph2, cpu_rst_n, cpu_ena, cpu_din
  );

  modport master (
    output in_valid, in_a, abort, out_ready, cpu_result, cpu_flag,
    input  in_ready, out_valid, out_result, out_flag_mask,
           cpu_ph1, cpu_ph2, cpu_rst_n, cpu_ena, cpu_din
  );
endinterface
`default_nettype wire

// File: rtl/rssb_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rssb_seq                                                     |
// | Description : Bit-serial job sequencer for the 1-bit RSSB CPU. Accepts an  |
// |               operand word, runs one CPU reset step, then streams the word |
// |               LSB-first (one bit per 4-cycle step) while collecting the    |
// |               per-step result and flag bits into output words.             |
// | Ports       : clk    - system clock, rising edge                           |
// |               rst_n  - asynchronous active-low reset                       |
// |               bus    - rssb_seq_if.slave (job, result and CPU pins)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rssb_seq #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  rssb_seq_if.slave   bus
);

  localparam int                 c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_p, w_p_nxt;
  logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_mask;
  logic                 r_ph1, r_ph2, r_cpu_rst_n, r_ena, r_din;
  logic                 w_accept;
  logic                 w_sample;
  logic                 w_active_nxt;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  // Result bit of the current step is taken on the edge that ends p==3,
  // unless that same edge cancels the job.
  assign w_sample = (r_state == S_RUN) && (r_p == 2'd3) && !bus.abort;
  // Strobes run only while the CPU is being cleared or stepped.
  assign w_active_nxt = (w_state_nxt == S_CLR) || (w_state_nxt == S_RUN);

  // Next-state / phase / step-index decode. Phase is 0 unless advancing.
  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = 2'd0;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_CLR;
          w_idx_nxt   = '0;
        end
      end
      S_CLR: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_p_nxt = r_p + 2'd1;
          if (r_p == 2'd3) begin
            w_state_nxt = S_RUN;
            w_idx_nxt   = '0;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_p_nxt = r_p + 2'd1;
          if (r_p == 2'd3) begin
            // Last step leaves the index at WIDTH-1 rather than wrapping.
            if (r_idx == c_last) w_state_nxt = S_DONE;
            else                 w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_p     <= 2'd0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Datapath and CPU pins. Pins are registered from the next-state values so
  // they line up with the state/phase they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_result    <= '0;
      r_mask      <= '0;
      r_ph1       <= 1'b0;
      r_ph2       <= 1'b0;
      r_cpu_rst_n <= 1'b1;
      r_ena       <= 1'b0;
      r_din       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.in_a;
        r_result <= '0;
        r_mask   <= '0;
      end else if (w_sample) begin
        r_result[r_idx] <= bus.cpu_result;
        r_mask[r_idx]   <= bus.cpu_flag;
      end
      r_ph1       <= w_active_nxt && (w_p_nxt == 2'd1);
      r_ph2       <= w_active_nxt && (w_p_nxt == 2'd2);
      r_cpu_rst_n <= (w_state_nxt != S_CLR);
      r_ena       <= (w_state_nxt == S_RUN);
      r_din       <= (w_state_nxt == S_RUN) ? r_a[w_idx_nxt] : 1'b0;
    end
  end

  assign bus.in_ready      = (r_state == S_IDLE);
  assign bus.out_valid     = (r_state == S_DONE);
  assign bus.out_result    = r_result;
  assign bus.out_flag_mask = r_mask;
  assign bus.cpu_ph1       = r_ph1;
  assign bus.cpu_ph2       = r_ph2;
  assign bus.cpu_rst_n     = r_cpu_rst_n;
  assign bus.cpu_ena       = r_ena;
  assign bus.cpu_din       = r_din;

endmodule
`default_nettype wire
